// File: rtl/dsc_s2b_rx_if.sv
// Frame-result bus of the DSC stochastic-to-binary receiver: sample inputs,
// frame control, and the valid/ready result register.
interface dsc_s2b_rx_if #(
  parameter int FRAME_LOG2 = 12
);
  logic                  en;
  logic                  start;
  logic                  sn_in;
  logic                  busy;
  logic [FRAME_LOG2:0]   z;
  logic                  z_valid;
  logic                  z_ready;
  logic                  lost;

  modport master (
    output en, start, sn_in, z_ready,
    input  busy, z, z_valid, lost
  );

  modport slave (
    input  en, start, sn_in, z_ready,
    output busy, z, z_valid, lost
  );
endinterface

// File: rtl/dsc_s2b_rx.sv
// Framed stochastic-to-binary receiver: counts ones over 2^FRAME_LOG2 enabled
// samples and delivers the exact count through a held valid/ready register.
module dsc_s2b_rx #(
  parameter int SNG_WIDTH  = 4,
  parameter int NUM_IN     = 3,
  parameter int FRAME_LOG2 = NUM_IN * SNG_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  dsc_s2b_rx_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                state_r;
  logic [FRAME_LOG2:0]   acc_r;
  logic [FRAME_LOG2-1:0] cnt_r;
  logic [FRAME_LOG2:0]   z_r;
  logic                  z_valid_r;
  logic                  busy_r;
  logic                  lost_r;

  logic [FRAME_LOG2:0]   final_s;
  logic                  last_s;
  logic                  frame_end_s;

  // Running count including the current sample, and frame-end detection.
  always_comb begin
    final_s     = acc_r + {{FRAME_LOG2{1'b0}}, bus.sn_in};
    last_s      = (cnt_r == {FRAME_LOG2{1'b1}});
    frame_end_s = 1'b0;
    if ((state_r == COUNT) && bus.en && last_s) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
  end

  // Frame FSM, accumulator, and result register with handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      acc_r     <= {(FRAME_LOG2+1){1'b0}};
      cnt_r     <= {FRAME_LOG2{1'b0}};
      z_r       <= {(FRAME_LOG2+1){1'b0}};
      z_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      lost_r    <= 1'b0;
    end else begin
      lost_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (bus.start) begin
            acc_r   <= {(FRAME_LOG2+1){1'b0}};
            cnt_r   <= {FRAME_LOG2{1'b0}};
            busy_r  <= 1'b1;
            state_r <= COUNT;
          end
        end
        COUNT: begin
          // sn_in only counts on enabled edges; cnt wraps to 0 at frame end.
          if (bus.en) begin
            acc_r <= final_s;
            cnt_r <= cnt_r + {{(FRAME_LOG2-1){1'b0}}, 1'b1};
            if (last_s) begin
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      // A held, unaccepted result wins over a newly finished frame.
      if (frame_end_s) begin
        if (!z_valid_r || bus.z_ready) begin
          z_r       <= final_s;
          z_valid_r <= 1'b1;
        end else begin
          lost_r <= 1'b1;
        end
      end else if (z_valid_r && bus.z_ready) begin
        z_valid_r <= 1'b0;
      end
    end
  end

  assign bus.busy    = busy_r;
  assign bus.z       = z_r;
  assign bus.z_valid = z_valid_r;
  assign bus.lost    = lost_r;

endmodule

// File: tb/tb_dsc_s2b_rx.sv
// Directed bench for dsc_s2b_rx with a 16-sample frame; expected counts are
// hand-computed from the stimulus patterns.
module tb_dsc_s2b_rx;
  localparam int FL2 = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  dsc_s2b_rx_if #(.FRAME_LOG2(FL2)) bus ();

  dsc_s2b_rx #(
    .SNG_WIDTH(4),
    .NUM_IN(3),
    .FRAME_LOG2(FL2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] z_e, input logic zv_e,
                         input logic busy_e, input logic lost_e);
    chk({tag, ".z"},       {27'd0, bus.z},      z_e);
    chk({tag, ".z_valid"}, {31'd0, bus.z_valid}, {31'd0, zv_e});
    chk({tag, ".busy"},    {31'd0, bus.busy},    {31'd0, busy_e});
    chk({tag, ".lost"},    {31'd0, bus.lost},    {31'd0, lost_e});
  endtask

  // Start strobe, then 16 enabled samples; z_ready asserted only on the last.
  task automatic frame(input logic [15:0] pat, input logic rdy_last);
    bus.start = 1'b1;
    bus.en    = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.en      = 1'b1;
      bus.sn_in   = pat[i];
      bus.z_ready = (i == 15) ? rdy_last : 1'b0;
      tick();
    end
    bus.en      = 1'b0;
    bus.sn_in   = 1'b0;
    bus.z_ready = 1'b0;
  endtask

  task automatic accept();
    bus.z_ready = 1'b1;
    tick();
    bus.z_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    logic [15:0] stall_pat;
    int          k;
    n_vec = 0;
    n_err = 0;
    rst         = 1'b0;
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.sn_in   = 1'b0;
    bus.z_ready = 1'b0;

    #1;
    chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("idle.z_valid", {31'd0, bus.z_valid}, 32'd0);
      chk("idle.busy",    {31'd0, bus.busy},    32'd0);
    end

    // Basic frame with 6 ones; start re-pulsed at cycle 10 must be ignored.
    pat = 16'b1010_0000_1100_0101;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("basic.busy_c1", {31'd0, bus.busy}, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      bus.en    = 1'b1;
      bus.sn_in = pat[i-1];
      bus.start = (i == 10);
      tick();
      if (i < 16) begin
        chk("basic.busy", {31'd0, bus.busy}, 32'd1);
        chk("basic.zv",   {31'd0, bus.z_valid}, 32'd0);
      end
    end
    bus.en    = 1'b0;
    bus.sn_in = 1'b0;
    bus.start = 1'b0;
    chk_out("basic.c17", 32'd6, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("basic.hold", 32'd6, 1'b1, 1'b0, 1'b0);
    accept();
    chk_out("basic.acc", 32'd6, 1'b0, 1'b0, 1'b0);

    frame(16'hFFFF, 1'b0);
    chk_out("full", 32'd16, 1'b1, 1'b0, 1'b0);
    accept();
    chk("full.acc", {31'd0, bus.z_valid}, 32'd0);
    frame(16'h0000, 1'b0);
    chk_out("zero", 32'd0, 1'b1, 1'b0, 1'b0);
    accept();

    // Stall: en=0 in cycles 5..9 with sn_in=1; 8 ones on enabled samples.
    stall_pat = 16'h3C3C;
    k = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      if (c >= 5 && c <= 9) begin
        bus.en    = 1'b0;
        bus.sn_in = 1'b1;
      end else begin
        bus.en    = 1'b1;
        bus.sn_in = stall_pat[k];
        k++;
      end
      tick();
      if (c == 16) chk_out("stall.c17", 32'd0, 1'b0, 1'b1, 1'b0);
      if (c == 20) chk_out("stall.c21", 32'd0, 1'b0, 1'b1, 1'b0);
    end
    bus.en    = 1'b0;
    bus.sn_in = 1'b0;
    chk_out("stall.c22", 32'd8, 1'b1, 1'b0, 1'b0);
    accept();

    // Backpressure: A held, B discarded with a single lost pulse.
    frame(16'h0007, 1'b0);
    chk_out("bp.A", 32'd3, 1'b1, 1'b0, 1'b0);
    frame(16'h01FF, 1'b0);
    chk_out("bp.B_lost", 32'd3, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("bp.after", 32'd3, 1'b1, 1'b0, 1'b0);
    accept();
    chk("bp.acc", {31'd0, bus.z_valid}, 32'd0);

    // Backpressure released on B's frame-end edge: B replaces A.
    frame(16'h0007, 1'b0);
    chk_out("bp2.A", 32'd3, 1'b1, 1'b0, 1'b0);
    frame(16'h01FF, 1'b1);
    chk_out("bp2.B", 32'd9, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("bp2.hold", 32'd9, 1'b1, 1'b0, 1'b0);

    // Async reset mid-frame with z_valid still set, then a clean frame.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.en    = 1'b1;
      bus.sn_in = 1'b1;
      tick();
    end
    chk_out("rst.pre", 32'd9, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("rst.async", 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.sn_in = 1'b0;
    tick();
    chk_out("rst.post", 32'd0, 1'b0, 1'b0, 1'b0);
    frame(16'h001F, 1'b0);
    chk_out("rst.new", 32'd5, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
